// File: rtl/wb_arbiter.sv
// Two-master to one-slave Wishbone B4 classic arbiter with grant held for the owner's whole cycle and a bus watchdog.
// Define WB_ARBITER_ROUND_ROBIN_EN to break simultaneous requests in favour of the master that did not own the bus last.
`timescale 1ns/1ps
module wb_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_toCnt;
  logic            w_stall;
  logic            w_toErr;
  logic            w_tieM1;

`ifdef WB_ARBITER_ROUND_ROBIN_EN
  logic r_lastOwner;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lastOwner <= 1'b0;
    end else if (w_next == GNT0) begin
      r_lastOwner <= 1'b0;
    end else if (w_next == GNT1) begin
      r_lastOwner <= 1'b1;
    end
  end

  assign w_tieM1 = ~r_lastOwner;
`else
  // The memory stage blocks retirement, so it wins ties.
  assign w_tieM1 = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_next = w_tieM1 ? GNT1 : GNT0;
        end else if (m1_cyc_i) begin
          w_next = GNT1;
        end else if (m0_cyc_i) begin
          w_next = GNT0;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          w_next = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          w_next = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_stall = s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;
  assign w_toErr = TO_EN && w_stall && (r_toCnt == TO_LAST);

  // Watchdog only counts uninterrupted stalls of the current owner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_toCnt <= '0;
    end else if ((r_state == IDLE) || (w_next != r_state) || s_ack_i || s_err_i || w_toErr) begin
      r_toCnt <= '0;
    end else if (w_stall && TO_EN) begin
      r_toCnt <= r_toCnt + 1'b1;
    end
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_addr_o = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    gnt_o    = 2'b00;
    case (r_state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_addr_o = m0_addr_i;
        s_dat_o  = m0_dat_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | w_toErr;
        gnt_o    = 2'b01;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_addr_o = m1_addr_i;
        s_dat_o  = m1_dat_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | w_toErr;
        gnt_o    = 2'b10;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus queues cycle-tagged expectations, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_wb_arbiter;

  typedef enum int {F_GNT, F_SCYC, F_SWE, F_SSEL, F_SADDR, F_SDAT,
                    F_M0ACK, F_M0ERR, F_M0DAT, F_M1ACK, F_M1ERR, F_M1DAT} fieldT;

  typedef struct {
    int          cyc;
    fieldT       fld;
    logic [31:0] val;
    string       name;
  } expT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0Cyc, m0Stb, m0We, m1Cyc, m1Stb, m1We;
  logic [3:0]  m0Sel, m1Sel, sSel;
  logic [31:0] m0Addr, m0DatW, m1Addr, m1DatW, m0DatR, m1DatR;
  logic        m0Ack, m0Err, m1Ack, m1Err;
  logic        sCyc, sStb, sWe, sAck, sErr;
  logic [31:0] sAddr, sDatW, sDatR;
  logic [1:0]  gnt;

  int  cycleCount = 0;
  int  checks = 0;
  int  failures = 0;
  bit  tieWinner;
  expT sbQ[$];

  wb_arbiter #(.TIMEOUT(4), .TO_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(m0Cyc), .m0_stb_i(m0Stb), .m0_we_i(m0We), .m0_sel_i(m0Sel),
    .m0_addr_i(m0Addr), .m0_dat_i(m0DatW), .m0_dat_o(m0DatR),
    .m0_ack_o(m0Ack), .m0_err_o(m0Err),
    .m1_cyc_i(m1Cyc), .m1_stb_i(m1Stb), .m1_we_i(m1We), .m1_sel_i(m1Sel),
    .m1_addr_i(m1Addr), .m1_dat_i(m1DatW), .m1_dat_o(m1DatR),
    .m1_ack_o(m1Ack), .m1_err_o(m1Err),
    .s_cyc_o(sCyc), .s_stb_o(sStb), .s_we_o(sWe), .s_sel_o(sSel),
    .s_addr_o(sAddr), .s_dat_o(sDatW), .s_dat_i(sDatR),
    .s_ack_i(sAck), .s_err_i(sErr), .gnt_o(gnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  function automatic logic [31:0] fieldValue(input fieldT f);
    case (f)
      F_GNT:   return {30'b0, gnt};
      F_SCYC:  return {31'b0, sCyc};
      F_SWE:   return {31'b0, sWe};
      F_SSEL:  return {28'b0, sSel};
      F_SADDR: return sAddr;
      F_SDAT:  return sDatW;
      F_M0ACK: return {31'b0, m0Ack};
      F_M0ERR: return {31'b0, m0Err};
      F_M0DAT: return m0DatR;
      F_M1ACK: return {31'b0, m1Ack};
      F_M1ERR: return {31'b0, m1Err};
      default: return m1DatR;
    endcase
  endfunction

  task automatic checkOutput(input expT e);
    logic [31:0] act;
    act = fieldValue(e.fld);
    checks++;
    if (act !== e.val) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=0x%h expected=0x%h", e.name, e.cyc, act, e.val);
    end
  endtask

  // Monitor: compares every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].cyc <= cycleCount) begin
      expT e;
      e = sbQ.pop_front();
      if (e.cyc < cycleCount) begin
        checks++;
        failures++;
        $display("[TB] FAIL stale_%s cycle=%0d got=unchecked expected=checked", e.name, e.cyc);
      end else begin
        checkOutput(e);
      end
    end
  end

  task automatic expectVal(input fieldT f, input logic [31:0] v, input string n);
    expT e;
    e.cyc  = cycleCount;
    e.fld  = f;
    e.val  = v;
    e.name = n;
    sbQ.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit master, input logic cyc, input logic stb, input logic we,
                               input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] dat);
    if (master) begin
      m1Cyc = cyc; m1Stb = stb; m1We = we; m1Sel = sel; m1Addr = addr; m1DatW = dat;
    end else begin
      m0Cyc = cyc; m0Stb = stb; m0We = we; m0Sel = sel; m0Addr = addr; m0DatW = dat;
    end
  endtask

  task automatic applySlave(input logic ack, input logic err, input logic [31:0] dat);
    sAck = ack; sErr = err; sDatR = dat;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout got=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
`ifdef WB_ARBITER_ROUND_ROBIN_EN
    tieWinner = 1'b0;
`else
    tieWinner = 1'b1;
`endif
    rst_n = 1'b0;
    applyStimulus(1'b1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1, 1, 0, 4'hF, 32'h100, 32'h0);
    applySlave(0, 0, 32'h0);

    $display("[TB] reset and first fetch read");
    step();
    expectVal(F_GNT, 32'h0, "rst_gnt");
    expectVal(F_SCYC, 32'h0, "rst_scyc");
    expectVal(F_SADDR, 32'h0, "rst_saddr");
    expectVal(F_M0ACK, 32'h0, "rst_m0ack");
    step();
    rst_n = 1'b1;
    expectVal(F_GNT, 32'h0, "first_cycle_idle");
    expectVal(F_SCYC, 32'h0, "first_cycle_scyc");
    step();
    applySlave(1, 0, 32'hDEADBEEF);
    expectVal(F_GNT, 32'h1, "m0_gnt");
    expectVal(F_SCYC, 32'h1, "m0_scyc");
    expectVal(F_SADDR, 32'h100, "m0_saddr");
    expectVal(F_M0ACK, 32'h1, "m0_ack");
    expectVal(F_M0DAT, 32'hDEADBEEF, "m0_dat");
    expectVal(F_M1ACK, 32'h0, "m0_m1ack");
    expectVal(F_M1DAT, 32'h0, "m0_m1dat");
    step();
    applyStimulus(1'b0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    applySlave(0, 0, 32'h0);
    expectVal(F_GNT, 32'h1, "m0_release_gnt");
    expectVal(F_SCYC, 32'h0, "m0_release_scyc");
    step();
    expectVal(F_GNT, 32'h0, "m0_idle");

    $display("[TB] store by master 1");
    applyStimulus(1'b1, 1, 1, 1, 4'h3, 32'h200, 32'h0000A5A5);
    expectVal(F_GNT, 32'h0, "st_req_idle");
    step();
    applySlave(1, 0, 32'h12345678);
    expectVal(F_GNT, 32'h2, "st_gnt");
    expectVal(F_SWE, 32'h1, "st_swe");
    expectVal(F_SSEL, 32'h3, "st_ssel");
    expectVal(F_SDAT, 32'h0000A5A5, "st_sdat");
    expectVal(F_SADDR, 32'h200, "st_saddr");
    expectVal(F_M1ACK, 32'h1, "st_m1ack");
    expectVal(F_M1DAT, 32'h12345678, "st_m1dat");
    expectVal(F_M0ACK, 32'h0, "st_m0ack");
    expectVal(F_M0DAT, 32'h0, "st_m0dat");
    expectVal(F_M0ERR, 32'h0, "st_m0err");
    step();
    applyStimulus(1'b1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    applySlave(0, 0, 32'h0);
    expectVal(F_SCYC, 32'h0, "st_release_scyc");
    step();
    expectVal(F_GNT, 32'h0, "st_idle");

    $display("[TB] simultaneous request and direct handover");
    applyStimulus(1'b0, 1, 1, 0, 4'hF, 32'h300, 32'h0);
    applyStimulus(1'b1, 1, 1, 1, 4'hF, 32'h400, 32'h11);
    step();
    applySlave(1, 0, 32'h55);
    expectVal(F_GNT, tieWinner ? 32'h2 : 32'h1, "tie_gnt");
    expectVal(F_SWE, {31'b0, tieWinner}, "tie_swe");
    expectVal(F_SADDR, tieWinner ? 32'h400 : 32'h300, "tie_saddr");
    expectVal(F_M1ACK, {31'b0, tieWinner}, "tie_m1ack");
    expectVal(F_M0ACK, {31'b0, ~tieWinner}, "tie_m0ack");
    step();
    applyStimulus(tieWinner, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    applySlave(0, 0, 32'h0);
    expectVal(F_GNT, tieWinner ? 32'h2 : 32'h1, "tie_release_gnt");
    expectVal(F_SCYC, 32'h0, "tie_release_scyc");
    step();
    applySlave(1, 0, 32'h66);
    expectVal(F_GNT, tieWinner ? 32'h1 : 32'h2, "handover_gnt");
    expectVal(F_SCYC, 32'h1, "handover_scyc");
    expectVal(F_SADDR, tieWinner ? 32'h300 : 32'h400, "handover_saddr");
    expectVal(tieWinner ? F_M0ACK : F_M1ACK, 32'h1, "handover_ack");
    step();
    applyStimulus(~tieWinner, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    applySlave(0, 0, 32'h0);
    expectVal(F_SCYC, 32'h0, "handover_release_scyc");
    step();
    expectVal(F_GNT, 32'h0, "handover_idle");

    $display("[TB] stalled master 1 with master 0 waiting");
    applyStimulus(1'b1, 1, 1, 0, 4'hF, 32'h500, 32'h0);
    step();
    applyStimulus(1'b0, 1, 1, 0, 4'hF, 32'h600, 32'h0);
    expectVal(F_GNT, 32'h2, "stall1_gnt");
    step();
    expectVal(F_GNT, 32'h2, "stall2_gnt");
    step();
    expectVal(F_GNT, 32'h2, "stall3_gnt");
    expectVal(F_M1ERR, 32'h0, "stall3_m1err");
    step();
    applySlave(1, 0, 32'hCAFEF00D);
    expectVal(F_GNT, 32'h2, "stall_ack_gnt");
    expectVal(F_M1ACK, 32'h1, "stall_ack_m1ack");
    expectVal(F_M1DAT, 32'hCAFEF00D, "stall_ack_m1dat");
    expectVal(F_M1ERR, 32'h0, "stall_ack_m1err");
    expectVal(F_M0ACK, 32'h0, "stall_ack_m0ack");
    step();
    applyStimulus(1'b1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    applySlave(0, 0, 32'h0);
    expectVal(F_GNT, 32'h2, "stall_release_gnt");
    expectVal(F_SCYC, 32'h0, "stall_release_scyc");
    step();
    expectVal(F_GNT, 32'h1, "direct_handover_gnt");
    expectVal(F_SADDR, 32'h600, "direct_handover_saddr");

    $display("[TB] watchdog on dead slave");
    expectVal(F_M0ERR, 32'h0, "to_cycle1_err");
    for (int k = 2; k <= 8; k++) begin
      step();
      expectVal(F_M0ERR, (k == 4 || k == 8) ? 32'h1 : 32'h0, $sformatf("to_cycle%0d_err", k));
      expectVal(F_M1ERR, 32'h0, $sformatf("to_cycle%0d_m1err", k));
    end
    step();
    applyStimulus(1'b0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    expectVal(F_M0ERR, 32'h0, "to_release_err");
    step();
    expectVal(F_GNT, 32'h0, "to_idle");

    $display("[TB] asynchronous reset mid-transfer");
    applyStimulus(1'b1, 1, 1, 0, 4'hF, 32'h700, 32'h0);
    step();
    expectVal(F_GNT, 32'h2, "rst_mid_gnt");
    expectVal(F_SCYC, 32'h1, "rst_mid_scyc");
    step();
    applySlave(1, 1, 32'h0BAD0BAD);
    expectVal(F_M1ACK, 32'h1, "ackerr_m1ack");
    expectVal(F_M1ERR, 32'h1, "ackerr_m1err");
    step();
    rst_n = 1'b0;
    expectVal(F_SCYC, 32'h0, "async_rst_scyc");
    expectVal(F_GNT, 32'h0, "async_rst_gnt");
    expectVal(F_M1ACK, 32'h0, "async_rst_m1ack");
    expectVal(F_M1ERR, 32'h0, "async_rst_m1err");
    step();
    rst_n = 1'b1;
    applyStimulus(1'b1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    applySlave(0, 0, 32'h0);
    expectVal(F_GNT, 32'h0, "post_rst_gnt");
    expectVal(F_M1ACK, 32'h0, "post_rst_m1ack");
    step();
    expectVal(F_GNT, 32'h0, "post_rst_idle");

    step();
    step();
    checks++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got=%0d expected=0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
